// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback and issues ALU commands, mux selects and all write enables.
module multicycle_control #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic [2:0] alu_command,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       zero_ext,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       exception,
    output logic       halted
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        IMMEX  = 4'd8,
        IMMWB  = 4'd9,
        BRANCH = 4'd10,
        JUMP   = 4'd11,
        JALS   = 4'd12,
        JR     = 4'd13,
        HALT   = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_SLT  = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_NOR  = 3'b110;
    localparam logic [2:0] ALU_OR   = 3'b111;

    state_t     state;
    logic       ovf_q;
    logic [2:0] rcmd;
    logic       rvalid;

    always_comb begin
        rvalid = 1'b1;
        rcmd   = ALU_ADD;
        case (funct)
            6'b100000: rcmd = ALU_ADD;
            6'b100010: rcmd = ALU_SUB;
            6'b100100: rcmd = ALU_AND;
            6'b100101: rcmd = ALU_OR;
            6'b100110: rcmd = ALU_XOR;
            6'b100111: rcmd = ALU_NOR;
            6'b101010: rcmd = ALU_SLT;
            default:   rvalid = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= state_t'(RESET_STATE);
            ovf_q <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    ovf_q <= 1'b0;
                    state <= DECODE;
                end
                DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW:     state <= MEMADR;
                        OP_RTYPE:         state <= (funct == FN_JR) ? JR : EXEC;
                        OP_BEQ, OP_BNE:   state <= BRANCH;
                        OP_J:             state <= JUMP;
                        OP_JAL:           state <= JALS;
                        OP_ADDI, OP_XORI: state <= IMMEX;
                        default:          state <= HALT;
                    endcase
                end
                MEMADR: state <= (opcode == OP_LW) ? MEMRD : MEMWR;
                MEMRD:  state <= MEMWB;
                EXEC: begin
                    if (rvalid) begin
                        ovf_q <= overflow;
                        state <= ALUWB;
                    end else begin
                        state <= HALT;
                    end
                end
                IMMEX: begin
                    ovf_q <= overflow;
                    state <= IMMWB;
                end
                MEMWB, MEMWR, ALUWB, IMMWB, BRANCH, JUMP, JALS, JR: state <= FETCH;
                default: state <= HALT;
            endcase
        end
    end

    always_comb begin
        alu_command = ALU_ADD;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        zero_ext    = 1'b0;
        iord        = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 2'b00;
        mem_to_reg  = 2'b00;
        pc_write    = 1'b0;
        pc_src      = 2'b00;
        exception   = 1'b0;
        halted      = 1'b0;
        case (state)
            FETCH: begin
                alu_src_b = 2'b01;
                ir_write  = 1'b1;
                pc_write  = 1'b1;
            end
            DECODE: alu_src_b = 2'b11;
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                mem_to_reg = 2'b01;
                reg_write  = 1'b1;
            end
            MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            EXEC: begin
                alu_src_a   = 1'b1;
                alu_command = rcmd;
            end
            ALUWB: begin
                reg_dst   = 2'b01;
                reg_write = ~ovf_q;
                exception = ovf_q;
            end
            IMMEX: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_command = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
                zero_ext    = (opcode == OP_XORI);
            end
            IMMWB: begin
                reg_write = ~ovf_q;
                exception = ovf_q;
            end
            BRANCH: begin
                alu_src_a   = 1'b1;
                alu_command = ALU_SUB;
                pc_src      = 2'b01;
                pc_write    = (opcode == OP_BEQ) ? zero : ~zero;
            end
            JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            JALS: begin
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                reg_write  = 1'b1;
                pc_src     = 2'b10;
                pc_write   = 1'b1;
            end
            JR: begin
                pc_src   = 2'b11;
                pc_write = 1'b1;
            end
            default: halted = 1'b1;
        endcase
        // Reset blocks every architectural write in the cycle it is asserted.
        if (reset) begin
            mem_write = 1'b0;
            reg_write = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: each instruction is expanded into its expected
// per-cycle control vectors and compared against the DUT every cycle.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       overflow = 1'b0;
    logic [2:0] alu_command;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       zero_ext;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       exception;
    logic       halted;

    multicycle_control #(.RESET_STATE(4'd0)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .overflow(overflow), .alu_command(alu_command),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .zero_ext(zero_ext),
        .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .pc_write(pc_write), .pc_src(pc_src), .exception(exception),
        .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] cmd;
        logic       sa;
        logic [1:0] sb;
        logic       zx;
        logic       iord;
        logic       mw;
        logic       irw;
        logic       rw;
        logic [1:0] rd;
        logic [1:0] m2r;
        logic       pw;
        logic [1:0] ps;
        logic       exc;
        logic       hlt;
    } ctl_t;

    ctl_t obs;
    assign obs = {alu_command, alu_src_a, alu_src_b, zero_ext, iord, mem_write,
                  ir_write, reg_write, reg_dst, mem_to_reg, pc_write, pc_src,
                  exception, halted};

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // ALU command for a legal R-type funct, -1 when the funct is not supported.
    function automatic int rcode(input logic [5:0] f);
        case (f)
            6'h20:   return 0;
            6'h22:   return 1;
            6'h24:   return 4;
            6'h25:   return 7;
            6'h26:   return 2;
            6'h27:   return 6;
            6'h2A:   return 3;
            default: return -1;
        endcase
    endfunction

    function automatic ctl_t masked(input ctl_t v);
        ctl_t m = v;
        m.mw  = 1'b0;
        m.rw  = 1'b0;
        m.irw = 1'b0;
        m.pw  = 1'b0;
        return m;
    endfunction

    task automatic check(input ctl_t exp, input string tag, input int k);
        @(negedge clk);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s c%0d: observed %h expected %h", tag, k, obs, exp);
        end
    endtask

    // Starts with the DUT in FETCH, one time unit after a rising edge.
    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic ov, input int rst_at, input string name);
        ctl_t q[$];
        bit   r[$];
        ctl_t v;
        int   c;
        bit   arith;
        bit   hlt;
        logic ovx;
        c     = (op == 6'h00) ? rcode(fn) : -1;
        arith = (c == 0) || (c == 1) || (op == 6'h08);
        ovx   = ov & arith;
        hlt   = 1'b0;
        v = '0; v.sb = 2'b01; v.irw = 1'b1; v.pw = 1'b1; q.push_back(v);
        v = '0; v.sb = 2'b11; q.push_back(v);
        case (op)
            6'h23, 6'h2B: begin
                v = '0; v.sa = 1'b1; v.sb = 2'b10; q.push_back(v);
                if (op == 6'h23) begin
                    v = '0; v.iord = 1'b1; q.push_back(v);
                    v = '0; v.m2r = 2'b01; v.rw = 1'b1; q.push_back(v);
                end else begin
                    v = '0; v.iord = 1'b1; v.mw = 1'b1; q.push_back(v);
                end
            end
            6'h00: begin
                if (fn == 6'h08) begin
                    v = '0; v.ps = 2'b11; v.pw = 1'b1; q.push_back(v);
                end else if (c >= 0) begin
                    v = '0; v.sa = 1'b1; v.cmd = c[2:0]; q.push_back(v);
                    v = '0; v.rd = 2'b01; v.rw = ~ovx; v.exc = ovx; q.push_back(v);
                end else begin
                    v = '0; v.sa = 1'b1; q.push_back(v);
                    hlt = 1'b1;
                end
            end
            6'h04, 6'h05: begin
                v = '0; v.sa = 1'b1; v.cmd = 3'b001; v.ps = 2'b01;
                v.pw = (op == 6'h04) ? z : ~z;
                q.push_back(v);
            end
            6'h02: begin
                v = '0; v.ps = 2'b10; v.pw = 1'b1; q.push_back(v);
            end
            6'h03: begin
                v = '0; v.rd = 2'b10; v.m2r = 2'b10; v.rw = 1'b1;
                v.ps = 2'b10; v.pw = 1'b1; q.push_back(v);
            end
            6'h08, 6'h0E: begin
                v = '0; v.sa = 1'b1; v.sb = 2'b10;
                v.cmd = (op == 6'h0E) ? 3'b010 : 3'b000;
                v.zx = (op == 6'h0E);
                q.push_back(v);
                v = '0; v.rw = ~ovx; v.exc = ovx; q.push_back(v);
            end
            default: hlt = 1'b1;
        endcase
        if (hlt) begin
            v = '0; v.hlt = 1'b1;
            for (int i = 0; i < 11; i++) q.push_back(v);
        end
        for (int i = 0; i < q.size(); i++) r.push_back(1'b0);
        if (hlt) r[r.size() - 1] = 1'b1;
        if (rst_at >= 0 && rst_at < q.size()) begin
            while (q.size() > rst_at + 1) begin
                void'(q.pop_back());
                void'(r.pop_back());
            end
            r[rst_at] = 1'b1;
        end
        opcode   = op;
        funct    = fn;
        zero     = z;
        overflow = ovx;
        for (int k = 0; k < q.size(); k++) begin
            reset = r[k];
            check(r[k] ? masked(q[k]) : q[k], name, k);
            @(posedge clk);
            #1;
            reset = 1'b0;
        end
    endtask

    logic [5:0] ops[11] = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h00, 6'h04, 6'h05,
                            6'h02, 6'h03, 6'h08, 6'h0E};
    logic [5:0] fns[8]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h08};

    initial begin
        ctl_t rv;
        logic [5:0] op;
        logic [5:0] fn;
        int ra;
        reset = 1'b1;
        @(posedge clk);
        #1;
        rv = '0; rv.sb = 2'b01;
        check(rv, "RESET", 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run(6'h23, 6'h00, 1'b0, 1'b0, -1, "LW");
        run(6'h00, 6'h22, 1'b0, 1'b1, -1, "SUB_OVF");
        run(6'h00, 6'h20, 1'b1, 1'b0, -1, "ADD");
        run(6'h00, 6'h2A, 1'b0, 1'b1, -1, "SLT");
        run(6'h04, 6'h00, 1'b1, 1'b0, -1, "BEQ_Z1");
        run(6'h04, 6'h00, 1'b0, 1'b0, -1, "BEQ_Z0");
        run(6'h05, 6'h00, 1'b1, 1'b0, -1, "BNE_Z1");
        run(6'h05, 6'h00, 1'b0, 1'b0, -1, "BNE_Z0");
        run(6'h03, 6'h00, 1'b0, 1'b0, -1, "JAL");
        run(6'h0E, 6'h00, 1'b0, 1'b1, -1, "XORI");
        run(6'h08, 6'h00, 1'b0, 1'b1, -1, "ADDI_OVF");
        run(6'h3F, 6'h00, 1'b0, 1'b0, -1, "HALT_OP");
        run(6'h2B, 6'h00, 1'b0, 1'b0, 3, "SW_RST");
        run(6'h2B, 6'h00, 1'b0, 1'b0, -1, "SW");
        run(6'h00, 6'h08, 1'b0, 1'b0, -1, "JR");
        run(6'h02, 6'h00, 1'b0, 1'b0, -1, "J");
        run(6'h00, 6'h3F, 1'b0, 1'b0, -1, "BAD_FUNCT");

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 15) == 0) op = 6'($urandom_range(0, 63));
            else op = ops[$urandom_range(0, 10)];
            if ($urandom_range(0, 9) == 0) fn = 6'($urandom_range(0, 63));
            else fn = fns[$urandom_range(0, 7)];
            ra = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 5)) : -1;
            run(op, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, "RAND");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
        $fatal(1, "watchdog");
    end

endmodule
